// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream driver: default sizes, FSM encoding
// and the coefficient sign-extension helper.
package fir_pkg;

  localparam int TAP_SIZE_DEF     = 6;
  localparam int NBR_OF_TAPS_DEF  = 3;
  localparam int X_N_SIZE_DEF     = 8;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int SETUP_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_WAIT_SETUP   = 3'd0,
    ST_IDLE         = 3'd1,
    ST_COEF_COLLECT = 3'd2,
    ST_COEF_PLAY    = 3'd3,
    ST_GAP          = 3'd4,
    ST_PRIME        = 3'd5,
    ST_STREAM       = 3'd6
  } fir_state_e;

  // Replicates bit (width-1) of val into every bit above it.
  function automatic logic [31:0] sign_ext(input logic [31:0] val, input logic [5:0] width);
    logic [31:0] upper;
    logic        sgn;
    upper = 32'hFFFF_FFFF << width;
    sgn   = |(val & (32'd1 << (width - 6'd1)));
    if (sgn) begin
      return val | upper;
    end else begin
      return val & ~upper;
    end
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO; pointers wrap naturally because DEPTH is a power of 2.
module fir_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;

  // Occupancy update for push, pop or both.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fir_stream_driver.sv
// Host-to-FIR driver: collects and replays coefficient sets, queues samples and
// streams them to the FIR with zero-fill on underrun. Outputs except host_ready are registered.
module fir_stream_driver
  import fir_pkg::*;
#(
  parameter int TAP_SIZE     = TAP_SIZE_DEF,
  parameter int NBR_OF_TAPS  = NBR_OF_TAPS_DEF,
  parameter int X_N_SIZE     = X_N_SIZE_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [X_N_SIZE-1:0] host_data,
  input  logic                host_cmd,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic                stream_en,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  output logic                coef_loaded,
  output logic [7:0]          underrun_cnt
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int IW = $clog2(NBR_OF_TAPS + 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NBR_OF_TAPS - 1);
  localparam logic [IW-1:0] PLAY_END   = IW'(NBR_OF_TAPS);

  fir_state_e          state_q, state_d;
  logic [SW-1:0]       setup_q, setup_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TAP_SIZE-1:0] coef_q [NBR_OF_TAPS];
  logic [TAP_SIZE-1:0] coef_d [NBR_OF_TAPS];
  logic [X_N_SIZE-1:0] x_n_q, x_n_d;
  logic                tvalid_q, tvalid_d;
  logic                set_q, set_d;
  logic                loaded_q, loaded_d;
  logic [7:0]          ur_q, ur_d;

  logic                ready_s, coef_acc_s, push_s, pop_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [X_N_SIZE-1:0] fifo_dout_s;
  logic [IW-1:0]       sel_s;

  // Acceptance depends on the byte kind: samples need FIFO room, coefficients an idle FSM.
  always_comb begin
    if (host_cmd) begin
      ready_s = (state_q == ST_IDLE) || (state_q == ST_COEF_COLLECT);
    end else begin
      ready_s = !fifo_full_s && (state_q != ST_WAIT_SETUP);
    end
  end

  assign coef_acc_s = host_valid && ready_s && host_cmd;
  assign push_s     = host_valid && ready_s && !host_cmd;
  assign sel_s      = LAST_IDX - idx_q;

  fir_sample_fifo #(
    .WIDTH (X_N_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push_s),
    .din_i   (host_data),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Next state and next output values; outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    setup_d  = setup_q;
    idx_d    = idx_q;
    coef_d   = coef_q;
    x_n_d    = '0;
    tvalid_d = 1'b0;
    set_d    = 1'b0;
    loaded_d = loaded_q;
    ur_d     = ur_q;
    pop_s    = 1'b0;
    case (state_q)
      ST_WAIT_SETUP: begin
        if (setup_q == SETUP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          setup_d = setup_q + SW'(1);
        end
      end
      ST_IDLE: begin
        if (coef_acc_s) begin
          coef_d[0] = host_data[TAP_SIZE-1:0];
          idx_d     = IW'(1);
          state_d   = ST_COEF_COLLECT;
        end else if (stream_en && !fifo_empty_s) begin
          tvalid_d = 1'b1;
          state_d  = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COEF_COLLECT: begin
        if (coef_acc_s) begin
          coef_d[idx_q] = host_data[TAP_SIZE-1:0];
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            set_d   = 1'b1;
            state_d = ST_COEF_PLAY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_COEF_COLLECT;
        end
      end
      // idx_q is the play cycle now on the outputs; the next one carries c(N-1-idx).
      ST_COEF_PLAY: begin
        if (idx_q == PLAY_END) begin
          loaded_d = 1'b1;
          state_d  = ST_GAP;
        end else begin
          idx_d = idx_q + IW'(1);
          set_d = 1'b1;
          x_n_d = X_N_SIZE'(sign_ext(32'(coef_q[sel_s]), 6'(TAP_SIZE)));
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      ST_PRIME, ST_STREAM: begin
        if (!fifo_empty_s) begin
          pop_s    = 1'b1;
          x_n_d    = fifo_dout_s;
          tvalid_d = 1'b1;
          state_d  = ST_STREAM;
        end else if (stream_en) begin
          tvalid_d = 1'b1;
          ur_d     = (ur_q == 8'hFF) ? ur_q : ur_q + 8'd1;
          state_d  = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_WAIT_SETUP;
      end
    endcase
  end

  // State, counters, coefficient store and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT_SETUP;
      setup_q  <= '0;
      idx_q    <= '0;
      for (int i = 0; i < NBR_OF_TAPS; i++) coef_q[i] <= '0;
      x_n_q    <= '0;
      tvalid_q <= 1'b0;
      set_q    <= 1'b0;
      loaded_q <= 1'b0;
      ur_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      setup_q  <= setup_d;
      idx_q    <= idx_d;
      coef_q   <= coef_d;
      x_n_q    <= x_n_d;
      tvalid_q <= tvalid_d;
      set_q    <= set_d;
      loaded_q <= loaded_d;
      ur_q     <= ur_d;
    end
  end

  assign host_ready     = ready_s;
  assign fir_x_n        = x_n_q;
  assign fir_tvalid     = tvalid_q;
  assign fir_set_coeffs = set_q;
  assign coef_loaded    = loaded_q;
  assign underrun_cnt   = ur_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver: a per-cycle vector table plus hand-written
// reset and handshake sequences; inputs change after posedge, outputs sampled at negedge.
module tb_fir_stream_driver;

  typedef struct {
    logic [7:0] data;
    logic       cmd;
    logic       valid;
    logic       sen;
    logic       e_rdy;
    logic [7:0] e_xn;
    logic       e_tv;
    logic       e_set;
    logic       e_ld;
    logic [7:0] e_ur;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       host_cmd = 1'b0;
  logic       host_valid = 1'b0;
  logic       stream_en = 1'b0;
  logic       host_ready;
  logic [7:0] fir_x_n;
  logic       fir_tvalid;
  logic       fir_set_coeffs;
  logic       coef_loaded;
  logic [7:0] underrun_cnt;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  fir_stream_driver dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .host_data      (host_data),
    .host_cmd       (host_cmd),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .stream_en      (stream_en),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs),
    .coef_loaded    (coef_loaded),
    .underrun_cnt   (underrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] data, input logic cmd, input logic valid,
                              input logic sen, input logic rdy, input logic [7:0] xn,
                              input logic tv, input logic set, input logic ld,
                              input logic [7:0] ur);
    vec_t v;
    v.data = data; v.cmd = cmd; v.valid = valid; v.sen = sen;
    v.e_rdy = rdy; v.e_xn = xn; v.e_tv = tv; v.e_set = set; v.e_ld = ld; v.e_ur = ur;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    host_data  = v.data;
    host_cmd   = v.cmd;
    host_valid = v.valid;
    stream_en  = v.sen;
  endtask

  task automatic check_now(input vec_t v, input string nm);
    logic [19:0] got, exp;
    got = {host_ready, fir_x_n, fir_tvalid, fir_set_coeffs, coef_loaded, underrun_cnt};
    exp = {v.e_rdy, v.e_xn, v.e_tv, v.e_set, v.e_ld, v.e_ur};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%0b xn=%02h tv=%0b set=%0b ld=%0b ur=%0d, want rdy=%0b xn=%02h tv=%0b set=%0b ld=%0b ur=%0d",
               nm, host_ready, fir_x_n, fir_tvalid, fir_set_coeffs, coef_loaded, underrun_cnt,
               v.e_rdy, v.e_xn, v.e_tv, v.e_set, v.e_ld, v.e_ur);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_now(v, nm);
  endtask

  initial begin
    // coefficient load 0x01,0x02,0x3F: replay lead 0, then c2..c0 sign-extended
    tbl.push_back(mk(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h3F, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    // samples 10,20,30 streamed after a prime cycle, then back to idle
    tbl.push_back(mk(8'h0A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h14, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h1E, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1E, 1'b1, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    // one sample with stream_en held: two zero-filled cycles
    tbl.push_back(mk(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    // fill the FIFO, refuse a fifth byte until a pop frees room
    tbl.push_back(mk(8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h05, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'd2));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2));

    // reset state, then setup window with a sample byte offered
    #1;
    reset_n = 1'b0;
    drive(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0));
    repeat (2) @(posedge clk);
    #1;
    check_now(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "reset_state");
    reset_n = 1'b1;
    @(negedge clk);
    check_now(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "setup0");
    for (int i = 1; i < 4; i++)
      apply(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), $sformatf("setup%0d", i));
    apply(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "setup_done");
    host_valid = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // coefficient byte offered during a stream is held off until tvalid drops
    apply(mk(8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2), "t5_push");
    apply(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2), "t5_idle");
    apply(mk(8'h21, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2), "t5_prime");
    apply(mk(8'h21, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 8'd2), "t5_stream");
    apply(mk(8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2), "t5_accept");
    apply(mk(8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2), "t5_c1");
    apply(mk(8'h23, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2), "t5_c2");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd2), "t5_play0");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hE3, 1'b0, 1'b1, 1'b1, 8'd2), "t5_play1");

    // asynchronous reset in the middle of a coefficient replay
    drive(mk(8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0));
    reset_n = 1'b0;
    #1;
    check_now(mk(8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "t6_async_rst");
    host_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_now(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "t6_setup0");
    for (int i = 1; i < 4; i++)
      apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), $sformatf("t6_setup%0d", i));
    apply(mk(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "t6_c0");
    apply(mk(8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "t6_c1");
    apply(mk(8'h09, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0), "t6_c2");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0), "t6_play0");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b0, 1'b1, 1'b0, 8'd0), "t6_play1");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 8'd0), "t6_play2");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0, 8'd0), "t6_play3");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0), "t6_gap");
    apply(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0), "t6_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
